id_stage: RTL
=============

Name: id_stage

Overview:
- Instruction-decode stage sitting directly downstream of instruction fetch.
- Captures fetched instruction/PC in an IF/ID register, decodes the MIPS subset, and reads a 32x32 register file with write-back bypass.
- Drives the branch/jump/jr controls back to fetch; detects load-use hazards and stalls fetch.
- Presents a registered, valid/ready ID/EX bundle to execute.

Parameters:
- RF_DEPTH, 32, number of architectural registers; register 0 reads as zero.
- DATA_W, 32, datapath width.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset, synchronous, active-low.
- if_inst  in  32  fetched instruction.
- if_pc  in  32  PC of if_inst.
- if_valid  in  1  if_inst/if_pc valid this cycle.
- if_stall  out  1  fetch must hold PC and instruction.
- flush  in  1  wrong-path kill from execute.
- ex_mem_read  in  1  instruction currently in EX is lw.
- ex_rt  in  5  destination of that lw.
- wb_en  in  1  register write enable.
- wb_addr  in  5  write address.
- wb_data  in  32  write data.
- out_ready  in  1  execute accepts ID/EX bundle.
- out_valid  out  1  ID/EX bundle valid.
- out_pc, out_rs_data, out_rt_data, out_imm  out  32 each  PC, operands, sign-extended imm (zero-extended for ori).
- out_dst  out  5  destination register (rd for R-type, rt for I-type, 31 for jal).
- out_alu_op  out  3  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lui.
- out_alu_src, out_mem_read, out_mem_write, out_reg_write  out  1 each.
- ct_branch, ct_jump, ct_jr  out  1 each  combinational, decoded from IF/ID contents, gated by IF/ID valid.

Behaviour:
- Reset (rst=0 at posedge):
  - IF/ID valid=0; all out_* = 0; all registers = 0.
  - if_stall=0 during reset.
- Decoded subset:
  - R-type (op 0x00): funct 0x21 addu, 0x23 subu, 0x24 and, 0x25 or, 0x2A slt, 0x08 jr.
  - I-type: 0x09 addiu, 0x0D ori, 0x0F lui, 0x23 lw, 0x2B sw, 0x04 beq.
  - J-type: 0x02 j, 0x03 jal.
  - Anything else decodes as NOP (reg_write=0, mem_*=0).
- beq: alu_op=sub, alu_src=0.
- Register file:
  - Written at posedge when wb_en && wb_addr!=0.
  - Reads are combinational with bypass: a read address equal to wb_addr while wb_en is set (addr!=0) returns wb_data.
  - Address 0 always returns 0.
- Hazard: hz = IF/ID valid && ex_mem_read && ex_rt!=0 && (ex_rt==rs || (uses_rt && ex_rt==rt)).
  - uses_rt applies to R-type, sw, beq.
- Backpressure: bp = out_valid && !out_ready.
- if_stall = (hz || bp) && !flush.
- Per cycle, priority flush > bp > hz > normal:
  - flush: IF/ID valid<=0; out_valid<=0; the flush cycle's if_inst is discarded.
  - bp: IF/ID and ID/EX hold.
  - hz: IF/ID holds; ID/EX loads a bubble (out_valid<=0, controls 0).
  - normal: ID/EX <= decode(IF/ID) with out_valid<=IF/ID valid; IF/ID <= {if_inst, if_pc}, valid<=if_valid.
- Latency: instruction presented with if_valid at edge N appears on out_* after edge N+1, absent stalls.
- ct_* reflect the IF/ID instruction, so fetch redirects in the same cycle the instruction is in ID; they are 0 while IF/ID is invalid.
- Reset mid-stall clears everything; there is no pending state.

Optional Feature:
- ILLEGAL_INST_TRAP_EN defined:
  - Adds output out_illegal (1, registered with the ID/EX bundle), set for undecodable op/funct.
  - Adds sticky output illegal_seen, cleared only by reset.
  - The instruction still travels as NOP.
- Undefined: neither port exists; illegal instructions are silent NOPs.

Test Plan:
- Reset, then addiu r1,r0,5 (0x24010005) with if_valid=1 -> two edges later out_valid=1, out_dst=1, out_imm=5, alu_op=0, alu_src=1, reg_write=1.
- wb_en=1, wb_addr=3, wb_data=0xDEAD_BEEF in the same cycle ID reads rs=3 -> out_rs_data=0xDEADBEEF; wb_addr=0 write -> r0 still reads 0.
- ex_mem_read=1, ex_rt=2, IF/ID holds addu r4,r2,r5 -> if_stall=1 for one cycle, a bubble (out_valid=0) is issued, then addu issues.
- out_valid=1, out_ready=0 for 3 cycles -> out_* and IF/ID unchanged, if_stall=1; out_ready=1 -> advance.
- j 0x0000100 in IF/ID -> ct_jump=1; flush=1 next cycle -> out_valid=0 and IF/ID invalid; flush with hazard active -> if_stall=0.
- With ILLEGAL_INST_TRAP_EN, op 0x3F -> out_illegal=1 and illegal_seen stays 1 until rst=0.

Source files
------------

// File: rtl/id_stage.sv
// MIPS-subset decode stage: IF/ID capture, bypassed 32x32 register file, load-use stall, valid/ready ID/EX register.
// Optional ILLEGAL_INST_TRAP_EN adds out_illegal and sticky illegal_seen.
module id_stage #(
    parameter int RF_DEPTH = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_inst,
    input  logic [31:0]       if_pc,
    input  logic              if_valid,
    output logic              if_stall,
    input  logic              flush,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [DATA_W-1:0] out_imm,
    output logic [4:0]        out_dst,
    output logic [2:0]        out_alu_op,
    output logic              out_alu_src,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_reg_write,
`ifdef ILLEGAL_INST_TRAP_EN
    output logic              out_illegal,
    output logic              illegal_seen,
`endif
    output logic              ct_branch,
    output logic              ct_jump,
    output logic              ct_jr
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_ORI = 6'h0D, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW  = 6'h2B;
    localparam logic [5:0] FN_JR  = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND = 6'h24, FN_OR   = 6'h25, FN_SLT  = 6'h2A;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3, ALU_SLT = 3'd4, ALU_LUI = 3'd5;

    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        dst;
        logic [2:0]        alu_op;
        logic              alu_src;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
    } idex_t;

    logic              ifid_valid_q, ifid_valid_d;
    logic [31:0]       ifid_inst_q, ifid_inst_d;
    logic [31:0]       ifid_pc_q, ifid_pc_d;
    logic [DATA_W-1:0] rf_q [RF_DEPTH];
    logic [DATA_W-1:0] rf_d [RF_DEPTH];
    idex_t             idex_q, idex_d, dec;
    logic [DATA_W-1:0] rs_rdata, rt_rdata;
    logic              hz, bp, uses_rt;
`ifdef ILLEGAL_INST_TRAP_EN
    logic              dec_illegal, illegal_q, illegal_d, seen_q, seen_d;
`endif

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    assign op    = ifid_inst_q[31:26];
    assign rs    = ifid_inst_q[25:21];
    assign rt    = ifid_inst_q[20:16];
    assign rd    = ifid_inst_q[15:11];
    assign imm16 = ifid_inst_q[15:0];
    assign funct = ifid_inst_q[5:0];

    always_comb begin
        rf_d = rf_q;
        if (wb_en && wb_addr != 5'd0) rf_d[wb_addr] = wb_data;
    end

    // A same-cycle write-back wins over the stored value; r0 is hardwired to zero.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later statements see earlier results.
        rs_rdata = rf_q[rs];
        if (rs == 5'd0)                         rs_rdata = '0;
        else if (wb_en && wb_addr == rs)        rs_rdata = wb_data;
        rt_rdata = rf_q[rt];
        if (rt == 5'd0)                         rt_rdata = '0;
        else if (wb_en && wb_addr == rt)        rt_rdata = wb_data;
    end

    always_comb begin
        // NOTE: every field gets a default before the case, so no latch can be inferred.
        dec         = '0;
        dec.valid   = 1'b1;
        dec.pc      = ifid_pc_q;
        dec.rs_data = rs_rdata;
        dec.rt_data = rt_rdata;
        dec.imm     = {{(DATA_W-16){imm16[15]}}, imm16};
`ifdef ILLEGAL_INST_TRAP_EN
        dec_illegal = 1'b0;
`endif
        case (op)
            OP_RTYPE: begin
                dec.dst       = rd;
                dec.reg_write = 1'b1;
                case (funct)
                    FN_ADDU: dec.alu_op = ALU_ADD;
                    FN_SUBU: dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_JR:   dec.reg_write = 1'b0;
                    default: begin
                        dec.dst       = '0;
                        dec.reg_write = 1'b0;
`ifdef ILLEGAL_INST_TRAP_EN
                        dec_illegal   = 1'b1;
`endif
                    end
                endcase
            end
            OP_ADDIU: begin dec.dst = rt; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
            OP_ORI: begin
                dec.dst = rt; dec.alu_op = ALU_OR; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.imm = {{(DATA_W-16){1'b0}}, imm16};
            end
            OP_LUI: begin dec.dst = rt; dec.alu_op = ALU_LUI; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
            OP_LW: begin
                dec.dst = rt; dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.reg_write = 1'b1;
            end
            OP_SW:  begin dec.dst = rt; dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
            OP_BEQ: begin dec.dst = rt; dec.alu_op = ALU_SUB; end
            OP_J:   ;
            OP_JAL: begin dec.dst = 5'd31; dec.reg_write = 1'b1; end
            default: begin
`ifdef ILLEGAL_INST_TRAP_EN
                dec_illegal = 1'b1;
`endif
            end
        endcase
    end

    assign uses_rt   = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    assign hz        = ifid_valid_q && ex_mem_read && (ex_rt != 5'd0) &&
                       ((ex_rt == rs) || (uses_rt && ex_rt == rt));
    assign bp        = idex_q.valid && !out_ready;
    assign if_stall  = rst && (hz || bp) && !flush;
    assign ct_branch = ifid_valid_q && (op == OP_BEQ);
    assign ct_jump   = ifid_valid_q && ((op == OP_J) || (op == OP_JAL));
    assign ct_jr     = ifid_valid_q && (op == OP_RTYPE) && (funct == FN_JR);

    // Priority: flush kills both stages, backpressure freezes both, a hazard inserts a bubble.
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_pc_d    = ifid_pc_q;
        idex_d       = idex_q;
`ifdef ILLEGAL_INST_TRAP_EN
        illegal_d    = illegal_q;
`endif
        if (flush) begin
            ifid_valid_d = 1'b0;
            idex_d       = '0;
`ifdef ILLEGAL_INST_TRAP_EN
            illegal_d    = 1'b0;
`endif
        end else if (bp) begin
            idex_d = idex_q;
        end else if (hz) begin
            idex_d = '0;
`ifdef ILLEGAL_INST_TRAP_EN
            illegal_d = 1'b0;
`endif
        end else begin
            idex_d       = ifid_valid_q ? dec : '0;
            ifid_valid_d = if_valid;
            ifid_inst_d  = if_inst;
            ifid_pc_d    = if_pc;
`ifdef ILLEGAL_INST_TRAP_EN
            illegal_d    = ifid_valid_q && dec_illegal;
`endif
        end
`ifdef ILLEGAL_INST_TRAP_EN
        seen_d = seen_q || illegal_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ifid_valid_q <= 1'b0;
            ifid_inst_q  <= '0;
            ifid_pc_q    <= '0;
            idex_q       <= '0;
            // NOTE: the register file is reset explicitly, so it maps to flops, not a RAM macro.
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
`ifdef ILLEGAL_INST_TRAP_EN
            illegal_q    <= 1'b0;
            seen_q       <= 1'b0;
`endif
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_pc_q    <= ifid_pc_d;
            idex_q       <= idex_d;
            rf_q         <= rf_d;
`ifdef ILLEGAL_INST_TRAP_EN
            illegal_q    <= illegal_d;
            seen_q       <= seen_d;
`endif
        end
    end

    assign out_valid     = idex_q.valid;
    assign out_pc        = idex_q.pc;
    assign out_rs_data   = idex_q.rs_data;
    assign out_rt_data   = idex_q.rt_data;
    assign out_imm       = idex_q.imm;
    assign out_dst       = idex_q.dst;
    assign out_alu_op    = idex_q.alu_op;
    assign out_alu_src   = idex_q.alu_src;
    assign out_mem_read  = idex_q.mem_read;
    assign out_mem_write = idex_q.mem_write;
    assign out_reg_write = idex_q.reg_write;
`ifdef ILLEGAL_INST_TRAP_EN
    assign out_illegal   = illegal_q;
    assign illegal_seen  = seen_q;
`endif

endmodule
